// File: rtl/line_doubler.sv
// Ping-pong scanline buffer: one source line is written while the other is
// replayed to the VGA side, doubled 2x horizontally and 2x vertically.
module line_doubler #(
   parameter int         LINE_WIDTH  = 320,
   parameter int         ACTIVE_ROWS = 480,
   parameter logic [7:0] BLANK_VALUE = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_valid,
   input  logic [7:0] wr_pixel,
   input  logic       wr_eol,
   output logic       wr_ready,
   input  logic [9:0] row,
   input  logic [9:0] col,
   output logic [7:0] uv_out,
   output logic [7:0] underflow_cnt
);

   localparam logic [9:0] ROW_LIMIT = 10'(ACTIVE_ROWS);
   localparam logic [9:0] COL_LIMIT = 10'(2 * LINE_WIDTH);
   localparam logic [8:0] LAST_PTR  = 9'(LINE_WIDTH - 1);

   typedef enum logic [0:0] {
      FILL = 1'b0,
      FULL = 1'b1
   } wr_state_t;

   wr_state_t  state_r;
   wr_state_t  state_next_s;
   logic       wr_ready_r;
   logic [8:0] wr_ptr_r;
   logic       wbank_r;
   logic       rd_valid_r;
   logic [8:0] len0_r;
   logic [8:0] len1_r;
   logic [9:0] prev_row_r;
   logic [7:0] underflow_cnt_r;
   logic [7:0] uv_out_r;
   logic [7:0] bank0_r [0:LINE_WIDTH-1];
   logic [7:0] bank1_r [0:LINE_WIDTH-1];

   logic       swap_evt_s;
   logic       accept_s;
   logic       last_s;
   logic [8:0] rd_addr_s;
   logic [8:0] rd_len_s;
   logic       blank_s;

   assign swap_evt_s = (row != prev_row_r) && (row[0] == 1'b0) && (row < ROW_LIMIT);
   assign accept_s   = wr_valid && wr_ready_r;
   assign last_s     = accept_s && (wr_eol || (wr_ptr_r == LAST_PTR));
   assign rd_addr_s  = col[9:1];
   // The read bank is always the one not being written.
   assign rd_len_s   = wbank_r ? len0_r : len1_r;
   assign blank_s    = !rd_valid_r || (row >= ROW_LIMIT) || (col >= COL_LIMIT) ||
                       (rd_addr_s >= rd_len_s);

   assign wr_ready      = wr_ready_r;
   assign uv_out        = uv_out_r;
   assign underflow_cnt = underflow_cnt_r;

   // Write FSM next-state decode.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         FILL: begin
            if (last_s) state_next_s = FULL;
            else        state_next_s = FILL;
         end
         FULL: begin
            if (swap_evt_s) state_next_s = FILL;
            else            state_next_s = FULL;
         end
         default: state_next_s = FILL;
      endcase
   end

   // Write FSM state and registered ready.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= FILL;
         wr_ready_r <= 1'b1;
      end else begin
         state_r    <= state_next_s;
         wr_ready_r <= (state_next_s == FILL);
      end
   end

   // Write pointer, bank select, line lengths and underflow accounting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r        <= 9'd0;
         wbank_r         <= 1'b0;
         rd_valid_r      <= 1'b0;
         len0_r          <= 9'd0;
         len1_r          <= 9'd0;
         prev_row_r      <= 10'd0;
         underflow_cnt_r <= 8'd0;
      end else begin
         prev_row_r <= row;
         if (last_s) begin
            wr_ptr_r <= 9'd0;
            if (wbank_r) len1_r <= wr_ptr_r + 9'd1;
            else         len0_r <= wr_ptr_r + 9'd1;
         end else if (accept_s) begin
            wr_ptr_r <= wr_ptr_r + 9'd1;
         end else if (swap_evt_s && (state_r == FULL)) begin
            wbank_r    <= ~wbank_r;
            wr_ptr_r   <= 9'd0;
            rd_valid_r <= 1'b1;
         end
         // A swap that finds the line still filling repeats the old line.
         if (swap_evt_s && (state_r == FILL) && (underflow_cnt_r != 8'hFF)) begin
            underflow_cnt_r <= underflow_cnt_r + 8'd1;
         end
      end
   end

   // Line storage; contents intentionally survive reset.
   always_ff @(posedge clk) begin
      if (accept_s && !reset) begin
         if (wbank_r) bank1_r[wr_ptr_r] <= wr_pixel;
         else         bank0_r[wr_ptr_r] <= wr_pixel;
      end
   end

   // Registered pixel read with blanking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         uv_out_r <= BLANK_VALUE;
      end else if (blank_s) begin
         uv_out_r <= BLANK_VALUE;
      end else if (wbank_r) begin
         uv_out_r <= bank0_r[rd_addr_s];
      end else begin
         uv_out_r <= bank1_r[rd_addr_s];
      end
   end

endmodule

// File: tb/tb_line_doubler.sv
// Self-checking bench for line_doubler: random stimulus against a queue-based
// model of "line being filled / line waiting / line on screen".
module tb_line_doubler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_pixel = 8'h00;
   logic       wr_eol = 1'b0;
   logic [9:0] row = 10'd0;
   logic [9:0] col = 10'd0;
   logic       wr_ready;
   logic [7:0] uv_out;
   logic [7:0] underflow_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] m_shown[$];
   logic [7:0] m_pending[$];
   logic [7:0] m_partial[$];
   bit         m_shown_valid;
   bit         m_full;
   logic [9:0] m_prev_row;
   logic [7:0] m_cnt;
   logic [7:0] exp_uv;
   bit         exp_acc;

   always #5 clk = ~clk;

   line_doubler dut (
      .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_pixel(wr_pixel),
      .wr_eol(wr_eol), .wr_ready(wr_ready), .row(row), .col(col),
      .uv_out(uv_out), .underflow_cnt(underflow_cnt)
   );

   task automatic model_reset();
      m_shown.delete();
      m_pending.delete();
      m_partial.delete();
      m_shown_valid = 1'b0;
      m_full        = 1'b0;
      m_prev_row    = 10'd0;
      m_cnt         = 8'd0;
      exp_uv        = 8'h00;
      exp_acc       = 1'b0;
   endtask

   // Drive one cycle, advance the model over the edge, return at edge+1.
   task automatic tick(input logic v, input logic [7:0] p, input logic e,
                       input logic [9:0] r, input logic [9:0] c);
      int a;
      bit swap;
      bit acc;
      wr_valid = v; wr_pixel = p; wr_eol = e; row = r; col = c;
      @(posedge clk);
      a = int'(c) / 2;
      if (!m_shown_valid || r >= 10'd480 || c >= 10'd640 || a >= m_shown.size())
         exp_uv = 8'h00;
      else
         exp_uv = m_shown[a];
      swap = (r != m_prev_row) && (r[0] == 1'b0) && (r < 10'd480);
      m_prev_row = r;
      acc = v && !m_full;
      if (swap) begin
         if (m_full) begin
            m_shown = m_pending;
            m_shown_valid = 1'b1;
            m_full = 1'b0;
         end else if (m_cnt != 8'd255) begin
            m_cnt = m_cnt + 8'd1;
         end
      end
      if (acc) begin
         m_partial.push_back(p);
         if (e || m_partial.size() == 320) begin
            m_pending = m_partial;
            m_partial.delete();
            m_full = 1'b1;
         end
      end
      exp_acc = acc;
      #1;
   endtask

   task automatic do_reset();
      wr_valid = 1'b0; wr_eol = 1'b0; row = 10'd0; col = 10'd0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      n_checks++;
      if (uv_out !== 8'h00 || wr_ready !== 1'b1 || underflow_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL reset: uv=%h ready=%b cnt=%0d, want 00 1 0", uv_out, wr_ready, underflow_cnt);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_blank_frame();
      for (int f = 0; f < 2; f++) begin
         for (int r = 0; r < 525; r++) begin
            for (int k = 0; k < 2; k++) begin
               tick(1'b0, 8'h00, 1'b0, 10'(r), (k == 0) ? 10'd0 : 10'($urandom_range(799, 0)));
               n_checks++;
               if (uv_out !== 8'h00 || wr_ready !== 1'b1 || underflow_cnt !== m_cnt) begin
                  n_fail++;
                  $display("FAIL blank_frame r=%0d: uv=%h ready=%b cnt=%0d, want 00 1 %0d",
                           r, uv_out, wr_ready, underflow_cnt, m_cnt);
               end
            end
         end
      end
      n_checks++;
      if (underflow_cnt !== 8'd255) begin
         n_fail++;
         $display("FAIL blank_saturate: cnt=%0d want 255", underflow_cnt);
      end
   endtask

   task automatic test_full_line();
      logic [7:0] row2_vals [0:639];
      do_reset();
      for (int i = 0; i < 320; i++) begin
         tick(1'b1, 8'(i), 1'b0, 10'd0, 10'd700);
         n_checks++;
         if (wr_ready !== !m_full || (i == 319 && wr_ready !== 1'b0)) begin
            n_fail++;
            $display("FAIL full_line_ready i=%0d: ready=%b want %b", i, wr_ready, !m_full);
         end
      end
      tick(1'b0, 8'h00, 1'b0, 10'd1, 10'd700);
      tick(1'b0, 8'h00, 1'b0, 10'd2, 10'd700);
      n_checks++;
      if (wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL full_line_swap_ready: ready=%b want 1", wr_ready);
      end
      for (int c = 0; c < 640; c++) begin
         tick(1'b0, 8'h00, 1'b0, 10'd2, 10'(c));
         row2_vals[c] = uv_out;
         n_checks++;
         if (uv_out !== exp_uv || uv_out !== 8'(c / 2)) begin
            n_fail++;
            $display("FAIL full_line_row2 c=%0d: uv=%h want %h", c, uv_out, 8'(c / 2));
         end
      end
      tick(1'b0, 8'h00, 1'b0, 10'd3, 10'd700);
      for (int c = 0; c < 640; c++) begin
         tick(1'b0, 8'h00, 1'b0, 10'd3, 10'(c));
         n_checks++;
         if (uv_out !== exp_uv || uv_out !== row2_vals[c]) begin
            n_fail++;
            $display("FAIL full_line_row3 c=%0d: uv=%h want %h", c, uv_out, row2_vals[c]);
         end
      end
   endtask

   task automatic test_short_line();
      logic [7:0] line [0:99];
      logic [7:0] want;
      for (int i = 0; i < 100; i++) begin
         line[i] = 8'($urandom_range(255, 0));
         tick(1'b1, line[i], (i == 99), 10'd3, 10'd700);
      end
      tick(1'b0, 8'h00, 1'b0, 10'd4, 10'd700);
      for (int c = 0; c < 640; c++) begin
         tick(1'b0, 8'h00, 1'b0, 10'd4, 10'(c));
         want = (c < 200) ? line[c / 2] : 8'h00;
         n_checks++;
         if (uv_out !== exp_uv || uv_out !== want) begin
            n_fail++;
            $display("FAIL short_line c=%0d: uv=%h want %h", c, uv_out, want);
         end
      end
   endtask

   task automatic test_back_to_back();
      int         got;
      logic [7:0] first_val;
      for (int i = 0; i < 50; i++) tick(1'b1, 8'($urandom_range(255, 0)), (i == 49), 10'd4, 10'd700);
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, 8'($urandom_range(255, 0)), 1'b0, 10'd4, 10'd700);
         n_checks++;
         if (wr_ready !== 1'b0 || exp_acc) begin
            n_fail++;
            $display("FAIL backpressure i=%0d: ready=%b want 0", i, wr_ready);
         end
      end
      tick(1'b1, 8'($urandom_range(255, 0)), 1'b0, 10'd5, 10'd700);
      tick(1'b1, 8'($urandom_range(255, 0)), 1'b0, 10'd6, 10'd700);
      got = 0;
      first_val = 8'h00;
      for (int i = 0; i < 40 && got < 10; i++) begin
         wr_pixel = 8'($urandom_range(255, 0));
         tick(1'b1, wr_pixel, (got == 9), 10'd6, 10'd700);
         if (exp_acc) begin
            if (got == 0) first_val = wr_pixel;
            got++;
         end
      end
      tick(1'b0, 8'h00, 1'b0, 10'd8, 10'd700);
      for (int c = 0; c < 24; c++) begin
         tick(1'b0, 8'h00, 1'b0, 10'd8, 10'(c));
         n_checks++;
         if (uv_out !== exp_uv || (c < 2 && uv_out !== first_val)) begin
            n_fail++;
            $display("FAIL back_to_back c=%0d: uv=%h want %h (first %h)", c, uv_out, exp_uv, first_val);
         end
      end
   endtask

   task automatic test_same_cycle();
      logic [7:0] a_line [0:19];
      logic [7:0] b_line [0:8];
      logic [7:0] want;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         a_line[i] = 8'($urandom_range(255, 1));
         tick(1'b1, a_line[i], (i == 19), 10'd0, 10'd700);
      end
      tick(1'b0, 8'h00, 1'b0, 10'd1, 10'd700);
      tick(1'b0, 8'h00, 1'b0, 10'd2, 10'd700);
      for (int i = 0; i < 8; i++) begin
         b_line[i] = 8'($urandom_range(255, 1));
         tick(1'b1, b_line[i], 1'b0, 10'd2, 10'd700);
      end
      b_line[8] = 8'($urandom_range(255, 1));
      tick(1'b1, b_line[8], 1'b1, 10'd4, 10'd700);
      n_checks++;
      if (underflow_cnt !== 8'd1 || wr_ready !== 1'b0 || underflow_cnt !== m_cnt) begin
         n_fail++;
         $display("FAIL same_cycle_evt: cnt=%0d ready=%b want 1 0", underflow_cnt, wr_ready);
      end
      for (int c = 0; c < 48; c++) begin
         tick(1'b0, 8'h00, 1'b0, 10'd4, 10'(c));
         want = (c < 40) ? a_line[c / 2] : 8'h00;
         n_checks++;
         if (uv_out !== exp_uv || uv_out !== want) begin
            n_fail++;
            $display("FAIL same_cycle_repeat c=%0d: uv=%h want %h", c, uv_out, want);
         end
      end
      tick(1'b0, 8'h00, 1'b0, 10'd5, 10'd700);
      tick(1'b0, 8'h00, 1'b0, 10'd6, 10'd700);
      for (int c = 0; c < 24; c++) begin
         tick(1'b0, 8'h00, 1'b0, 10'd6, 10'(c));
         want = (c < 18) ? b_line[c / 2] : 8'h00;
         n_checks++;
         if (uv_out !== exp_uv || uv_out !== want || underflow_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL same_cycle_next c=%0d: uv=%h want %h cnt=%0d", c, uv_out, want, underflow_cnt);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] line [0:4];
      for (int i = 0; i < 150; i++) tick(1'b1, 8'($urandom_range(255, 0)), 1'b0, 10'd6, 10'd1);
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (uv_out !== 8'h00 || wr_ready !== 1'b1 || underflow_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_mid: uv=%h ready=%b cnt=%0d, want 00 1 0", uv_out, wr_ready, underflow_cnt);
      end
      do_reset();
      for (int i = 0; i < 5; i++) begin
         line[i] = 8'($urandom_range(255, 1));
         tick(1'b1, line[i], (i == 4), 10'd0, 10'd700);
      end
      tick(1'b0, 8'h00, 1'b0, 10'd2, 10'd700);
      for (int c = 0; c < 16; c++) begin
         tick(1'b0, 8'h00, 1'b0, 10'd2, 10'(c));
         n_checks++;
         if (uv_out !== exp_uv || (c < 10 && uv_out !== line[c / 2])) begin
            n_fail++;
            $display("FAIL reset_mid_rewrite c=%0d: uv=%h want %h", c, uv_out, exp_uv);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_blank_frame();
      test_full_line();
      test_short_line();
      test_back_to_back();
      test_same_cycle();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
